rv_iopmp_match_scheduler: RTL and testbench
===========================================

# rv_iopmp_match_scheduler

Sequential controller that resolves one IOPMP access check by walking the entry table one entry per cycle through a single `rv_iopmp_entry_analyzer`. It sits between the request-side checker (which supplies address, size, type and the entry index range of the requesting memory domain) and the entry register file (combinational read port). It returns the first, i.e. highest-priority, matching entry and an allow/deny verdict over a valid/ready response handshake.

## Interface

**Parameters**
- `NumEntries`, 64: number of entries in the table; `IdxW = $clog2(NumEntries)`.
- `ADDR_WIDTH`, 64: transaction address width.
- `DATA_WIDTH`, 64: bus data width; sets the `num_bytes` width.
- `LEN`, 32: entry register width.

**Ports**
- Clocking and reset: one clock, `clk_i`; reset `rst_i`, asynchronous, active-high.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: asynchronous active-high reset.
- `enable_i`, in, 1: IOPMP global enable.
- `flush_i`, in, 1: the entry table was written; restart any walk in progress.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: request ready.
- `req_addr_i`, in, ADDR_WIDTH: transaction address.
- `req_num_bytes_i`, in, $clog2(DATA_WIDTH/8)+1: access size in bytes.
- `req_type_i`, in, `access_t`: transaction type.
- `req_start_i`, in, IdxW+1: first entry index (inclusive).
- `req_end_i`, in, IdxW+1: end entry index (exclusive).
- `entry_idx_o`, out, IdxW: entry read index.
- `entry_addr_i`, in, LEN: entry address, low word, for `entry_idx_o`.
- `entry_addrh_i`, in, LEN: entry address, high word, for `entry_idx_o`.
- `entry_mode_i`, in, `mode_t`: entry address-matching mode.
- `entry_perm_i`, in, 3: entry permissions.
- `rsp_valid_o`, out, 1: response valid.
- `rsp_ready_i`, in, 1: response ready.
- `rsp_allow_o`, out, 1: access permitted.
- `rsp_hit_o`, out, 1: some entry matched.
- `rsp_entry_o`, out, IdxW: index of the matching entry.
- `rsp_err_o`, out, `walk_err_t`: error code.

## Operation

**States** (`walk_state_t`)
- **IDLE**:
  - `req_ready_o = 1`.
  - On handshake, register the address, size, type, start and end.
  - If `enable_i = 0`, go to RESP with allow=1, hit=0, err=ERR_NONE.
  - Else if `start >= end`, go to RESP with allow=0, hit=0, err=ERR_NO_HIT.
  - Else if `start == 0`, go to WALK with `prev_addr = 0` and `idx = 0`.
  - Else go to PRIME.
- **PRIME**:
  - `entry_idx_o = start-1`.
  - Latch `{addrh,addr}` into `prev_addr`; set `idx = start`; go to WALK.
  - The entry's mode and permissions are ignored.
- **WALK**:
  - `entry_idx_o = idx`; the analyzer gets the registered request, the entry fields and `prev_addr`.
  - On match: go to RESP with hit=1, entry=idx, allow=analyzer allow, err=ERR_NONE if allow else ERR_DENIED.
  - On no match: `prev_addr <= {addrh,addr}`, `idx++`.
  - If `idx+1 == end` with no match, go to RESP with allow=0, hit=0, err=ERR_NO_HIT.
- **RESP**:
  - `rsp_valid_o = 1`; the `rsp_*` fields are held stable.
  - On `rsp_ready_i`, go to IDLE.

**Flush**
- `flush_i` in PRIME or WALK restarts the walk from the registered start (same path as at acceptance), discarding any match found in that cycle. Flush wins over a simultaneous hit.
- `flush_i` in IDLE or RESP has no effect.

**Other rules**
- `entry_idx_o` is 0 in IDLE and RESP.
- The OFF mode never matches. This applies to every entry, including the last.
- `idx` and end comparisons use IdxW+1 bits, so `end == NumEntries` does not wrap.
- Reset mid-walk returns to IDLE. No response is emitted for the aborted request.

## Timing
- Reset values:
  - state IDLE, `req_ready_o = 1`, `rsp_valid_o = 0`.
  - `rsp_allow_o`, `rsp_hit_o`, `rsp_entry_o` = 0.
  - `rsp_err_o` = ERR_NONE, `entry_idx_o` = 0.
- Request accepted at cycle T. The first entry is examined at T+1 if `start == 0`, otherwise at T+2 (after PRIME). Entry `start+k` is examined k cycles later.
- Entry examined at cycle C with a hit, or last entry with no match: `rsp_valid_o` rises at C+1.
- Disabled or empty range: `rsp_valid_o` at T+1.
- Back-to-back throughput: `req_ready_o` returns to 1 the cycle after the response handshake. There is no overlap between requests.
- All outputs are registered or derived from state only. There is no combinational path from `req_*` or `rsp_ready_i` to any output.

## Structure
- `rv_iopmp_pkg` additions:
  - `walk_state_t` {IDLE, PRIME, WALK, RESP}.
  - `walk_err_t` 2-bit {ERR_NONE, ERR_NO_HIT, ERR_DENIED}.
- One sub-module: `rv_iopmp_entry_analyzer`, instantiated once with `CHECK_LEN = 2*LEN+2`.

## Test plan
- Range [0,4), entry 2 is NAPOT at 0x1000 size 4 KiB with RW; entries 0, 1 OFF. Read at 0x1008, 8 bytes, accepted at T -> `rsp_valid` at T+4, hit=1, entry=2, allow=1, err=NONE.
- Range [3,5), entry 2 addr 0x400 (0x1000>>2), entry 3 TOR addr 0x800 with R only. Write at 0x1800 -> PRIME at T+1, match at T+2, response at T+3: hit=1, entry=3, allow=0, err=DENIED.
- Range [5,5) -> response at T+1: hit=0, err=NO_HIT. Same request with `enable_i = 0` -> allow=1, err=NONE.
- Range [0,3), nothing matches. Hold `rsp_ready_i = 0` for 5 cycles -> `rsp_valid` stays high with constant fields; `req_ready_o` stays 0 until the handshake.
- Hit on entry 1 in the same cycle as `flush_i` -> no response that cycle; walk restarts at entry 0 and responds with entry 1 two cycles later.
- `rst_i` asserted mid-WALK -> outputs at reset values immediately (asynchronous); no spurious `rsp_valid` after deassertion.

Source files
------------

// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access/mode encodings and the match-scheduler state and error codes.
package rv_iopmp_pkg;

  typedef enum logic [2:0] {
    ACCESS_NONE  = 3'b000,
    ACCESS_READ  = 3'b001,
    ACCESS_WRITE = 3'b010,
    ACCESS_EXEC  = 3'b100
  } access_t;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_TOR   = 2'd1,
    MODE_NA4   = 2'd2,
    MODE_NAPOT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    WALK  = 2'd2,
    RESP  = 2'd3
  } walk_state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_NO_HIT = 2'd1,
    ERR_DENIED = 2'd2
  } walk_err_t;

endpackage

// File: rtl/rv_iopmp_entry_analyzer.sv
// Combinational check of one access against one entry: match on the first byte,
// allow only if the last byte is also covered and the permissions include the access type.
module rv_iopmp_entry_analyzer
  import rv_iopmp_pkg::*;
#(
  parameter int CHECK_LEN  = 66,
  parameter int ADDR_WIDTH = 64,
  parameter int NB_W       = 4
) (
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [NB_W-1:0]        num_bytes_i,
  input  access_t                type_i,
  input  logic [CHECK_LEN-3:0]   entry_addr_i,
  input  logic [CHECK_LEN-3:0]   prev_addr_i,
  input  mode_t                  mode_i,
  input  logic [2:0]             perm_i,
  output logic                   match_o,
  output logic                   allow_o
);

  logic [CHECK_LEN-1:0] first_byte, last_byte, cur_base, prev_base, napot_ones, napot_mask;

  // Entry registers hold byte address >> 2; NAPOT size comes from the trailing ones.
  assign first_byte = CHECK_LEN'(addr_i);
  assign last_byte  = (num_bytes_i == '0) ? first_byte
                                          : first_byte + CHECK_LEN'(num_bytes_i) - CHECK_LEN'(1);
  assign cur_base   = {entry_addr_i, 2'b00};
  assign prev_base  = {prev_addr_i, 2'b00};
  assign napot_ones = {entry_addr_i, 2'b11};
  assign napot_mask = napot_ones ^ (napot_ones + CHECK_LEN'(1));

  function automatic logic in_region(input logic [CHECK_LEN-1:0] x, input mode_t mode,
                                     input logic [CHECK_LEN-1:0] lo,
                                     input logic [CHECK_LEN-1:0] hi,
                                     input logic [CHECK_LEN-1:0] mask);
    case (mode)
      MODE_TOR:   in_region = (x >= lo) && (x < hi);
      MODE_NA4:   in_region = (x[CHECK_LEN-1:2] == hi[CHECK_LEN-1:2]);
      MODE_NAPOT: in_region = ((x & ~mask) == (hi & ~mask));
      default:    in_region = 1'b0;
    endcase
  endfunction

  assign match_o = in_region(first_byte, mode_i, prev_base, cur_base, napot_mask);
  assign allow_o = match_o
                && in_region(last_byte, mode_i, prev_base, cur_base, napot_mask)
                && ((perm_i & 3'(type_i)) == 3'(type_i));

endmodule

// File: rtl/rv_iopmp_match_scheduler.sv
// Walks the entry table one entry per cycle and reports the first matching entry.
// Handshakes: a transfer happens on a cycle where valid and ready are both high; valid never waits on ready.
module rv_iopmp_match_scheduler
  import rv_iopmp_pkg::*;
#(
  parameter int NumEntries = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LEN        = 32,
  localparam int IdxW      = $clog2(NumEntries),
  localparam int NbW       = $clog2(DATA_WIDTH/8) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NbW-1:0]        req_num_bytes_i,
  input  access_t               req_type_i,
  input  logic [IdxW:0]         req_start_i,
  input  logic [IdxW:0]         req_end_i,
  output logic [IdxW-1:0]       entry_idx_o,
  input  logic [LEN-1:0]        entry_addr_i,
  input  logic [LEN-1:0]        entry_addrh_i,
  input  mode_t                 entry_mode_i,
  input  logic [2:0]            entry_perm_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_allow_o,
  output logic                  rsp_hit_o,
  output logic [IdxW-1:0]       rsp_entry_o,
  output walk_err_t             rsp_err_o
);

  localparam logic [IdxW:0] IdxOne = (IdxW+1)'(1);

  walk_state_t           state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NbW-1:0]        num_bytes_q;
  access_t               type_q;
  logic [IdxW:0]         start_q, end_q, idx_q;
  logic [2*LEN-1:0]      prev_q;
  logic [2*LEN-1:0]      entry_word;
  logic                  hit, allow;

  assign entry_word  = {entry_addrh_i, entry_addr_i};
  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

  always_comb begin
    entry_idx_o = '0;
    case (state)
      PRIME:   entry_idx_o = IdxW'(start_q - IdxOne);
      WALK:    entry_idx_o = idx_q[IdxW-1:0];
      default: entry_idx_o = '0;
    endcase
  end

  rv_iopmp_entry_analyzer #(
    .CHECK_LEN  (2*LEN + 2),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NB_W       (NbW)
  ) u_analyzer (
    .addr_i       (addr_q),
    .num_bytes_i  (num_bytes_q),
    .type_i       (type_q),
    .entry_addr_i (entry_word),
    .prev_addr_i  (prev_q),
    .mode_i       (entry_mode_i),
    .perm_i       (entry_perm_i),
    .match_o      (hit),
    .allow_o      (allow)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      addr_q      <= '0;
      num_bytes_q <= '0;
      type_q      <= ACCESS_NONE;
      start_q     <= '0;
      end_q       <= '0;
      idx_q       <= '0;
      prev_q      <= '0;
      rsp_allow_o <= 1'b0;
      rsp_hit_o   <= 1'b0;
      rsp_entry_o <= '0;
      rsp_err_o   <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q      <= req_addr_i;
            num_bytes_q <= req_num_bytes_i;
            type_q      <= req_type_i;
            start_q     <= req_start_i;
            end_q       <= req_end_i;
            rsp_hit_o   <= 1'b0;
            rsp_entry_o <= '0;
            if (!enable_i) begin
              state       <= RESP;
              rsp_allow_o <= 1'b1;
              rsp_err_o   <= ERR_NONE;
            end else if (req_start_i >= req_end_i) begin
              state       <= RESP;
              rsp_allow_o <= 1'b0;
              rsp_err_o   <= ERR_NO_HIT;
            end else if (req_start_i == '0) begin
              state  <= WALK;
              idx_q  <= '0;
              prev_q <= '0;
            end else begin
              state <= PRIME;
            end
          end
        end
        PRIME: begin
          // A flush here re-enters PRIME (start is nonzero), re-reading the neighbour entry.
          if (!flush_i) begin
            prev_q <= entry_word;
            idx_q  <= start_q;
            state  <= WALK;
          end
        end
        WALK: begin
          if (flush_i) begin
            idx_q  <= '0;
            prev_q <= '0;
            state  <= (start_q == '0) ? WALK : PRIME;
          end else if (hit) begin
            state       <= RESP;
            rsp_hit_o   <= 1'b1;
            rsp_entry_o <= idx_q[IdxW-1:0];
            rsp_allow_o <= allow;
            rsp_err_o   <= allow ? ERR_NONE : ERR_DENIED;
          end else begin
            prev_q <= entry_word;
            idx_q  <= idx_q + IdxOne;
            if (idx_q + IdxOne == end_q) begin
              state       <= RESP;
              rsp_allow_o <= 1'b0;
              rsp_err_o   <= ERR_NO_HIT;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_iopmp_match_scheduler.sv
// Directed bench for the IOPMP match scheduler with a small behavioural entry table.
module tb_rv_iopmp_match_scheduler;
  import rv_iopmp_pkg::*;

  localparam int NE = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, flush, req_valid, rsp_ready;
  logic        req_ready, rsp_valid, rsp_allow, rsp_hit;
  logic [63:0] req_addr;
  logic [3:0]  req_nb;
  access_t     req_type;
  logic [6:0]  req_start, req_end;
  logic [5:0]  entry_idx, rsp_entry;
  logic [31:0] entry_addr, entry_addrh;
  mode_t       entry_mode;
  logic [2:0]  entry_perm;
  walk_err_t   rsp_err;

  logic [31:0] t_addr  [NE];
  logic [31:0] t_addrh [NE];
  mode_t       t_mode  [NE];
  logic [2:0]  t_perm  [NE];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign entry_addr  = t_addr[entry_idx];
  assign entry_addrh = t_addrh[entry_idx];
  assign entry_mode  = t_mode[entry_idx];
  assign entry_perm  = t_perm[entry_idx];

  rv_iopmp_match_scheduler dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .flush_i         (flush),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_num_bytes_i (req_nb),
    .req_type_i      (req_type),
    .req_start_i     (req_start),
    .req_end_i       (req_end),
    .entry_idx_o     (entry_idx),
    .entry_addr_i    (entry_addr),
    .entry_addrh_i   (entry_addrh),
    .entry_mode_i    (entry_mode),
    .entry_perm_i    (entry_perm),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_allow_o     (rsp_allow),
    .rsp_hit_o       (rsp_hit),
    .rsp_entry_o     (rsp_entry),
    .rsp_err_o       (rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < NE; i++) begin
      t_addr[i]  = '0;
      t_addrh[i] = '0;
      t_mode[i]  = MODE_OFF;
      t_perm[i]  = '0;
    end
  endtask

  task automatic drive_req(input int s, input int e, input logic [63:0] a,
                           input logic [3:0] nb, input access_t t);
    check("req_ready_before", 64'(req_ready), 64'd1);
    req_start = 7'(s);
    req_end   = 7'(e);
    req_addr  = a;
    req_nb    = nb;
    req_type  = t;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Returns the number of cycles after acceptance until rsp_valid is seen.
  task automatic do_req(input int s, input int e, input logic [63:0] a,
                        input logic [3:0] nb, input access_t t, output int lat);
    drive_req(s, e, a, nb, t);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_rsp(input string tag, input int lat, input int exp_lat, input logic allow,
                           input logic hit, input int entry, input walk_err_t err);
    check({tag, "_lat"},   64'(lat),       64'(exp_lat));
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_allow"}, 64'(rsp_allow), 64'(allow));
    check({tag, "_hit"},   64'(rsp_hit),   64'(hit));
    check({tag, "_entry"}, 64'(rsp_entry), 64'(entry));
    check({tag, "_err"},   64'(rsp_err),   64'(err));
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_ready_after"}, 64'(req_ready), 64'd1);
    check({tag, "_valid_after"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    enable = 1'b1;
    flush = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_addr = '0;
    req_nb = '0;
    req_type = ACCESS_NONE;
    req_start = '0;
    req_end = '0;
    clear_table();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_allow",     64'(rsp_allow), 64'd0);
    check("rst_hit",       64'(rsp_hit),   64'd0);
    check("rst_entry",     64'(rsp_entry), 64'd0);
    check("rst_err",       64'(rsp_err),   64'(ERR_NONE));
    check("rst_entry_idx", 64'(entry_idx), 64'd0);
    @(negedge clk);

    // NAPOT 4 KiB at 0x1000, RW, walked from entry 0.
    clear_table();
    t_mode[2] = MODE_NAPOT; t_addr[2] = 32'h5FF; t_perm[2] = 3'b011;
    do_req(0, 4, 64'h1008, 4'd8, ACCESS_READ, lat);
    check_rsp("napot", lat, 4, 1'b1, 1'b1, 2, ERR_NONE);
    ack_rsp("napot");

    // TOR [0x1000,0x2000) read-only, write is denied; PRIME reads entry 2.
    clear_table();
    t_addr[2] = 32'h400;
    t_mode[3] = MODE_TOR; t_addr[3] = 32'h800; t_perm[3] = 3'b001;
    do_req(3, 5, 64'h1800, 4'd8, ACCESS_WRITE, lat);
    check_rsp("tor_deny", lat, 3, 1'b0, 1'b1, 3, ERR_DENIED);
    ack_rsp("tor_deny");

    do_req(5, 5, 64'h1800, 4'd8, ACCESS_WRITE, lat);
    check_rsp("empty", lat, 1, 1'b0, 1'b0, 0, ERR_NO_HIT);
    ack_rsp("empty");

    enable = 1'b0;
    do_req(5, 5, 64'h1800, 4'd8, ACCESS_WRITE, lat);
    check_rsp("disabled", lat, 1, 1'b1, 1'b0, 0, ERR_NONE);
    ack_rsp("disabled");
    enable = 1'b1;

    // Range ending at NumEntries: hit on the last entry, then a miss that must not wrap.
    clear_table();
    t_addr[62] = 32'h4000;
    t_mode[63] = MODE_TOR; t_addr[63] = 32'h8000; t_perm[63] = 3'b111;
    do_req(62, 64, 64'h10000, 4'd4, ACCESS_EXEC, lat);
    check_rsp("last_hit", lat, 4, 1'b1, 1'b1, 63, ERR_NONE);
    ack_rsp("last_hit");
    do_req(62, 64, 64'h30000, 4'd4, ACCESS_EXEC, lat);
    check_rsp("last_miss", lat, 4, 1'b0, 1'b0, 0, ERR_NO_HIT);
    ack_rsp("last_miss");

    // OFF entry whose TOR interpretation would cover the address.
    clear_table();
    t_addr[1] = 32'h800; t_perm[1] = 3'b111;
    do_req(1, 2, 64'h100, 4'd4, ACCESS_READ, lat);
    check_rsp("off_last", lat, 3, 1'b0, 1'b0, 0, ERR_NO_HIT);
    ack_rsp("off_last");

    // Miss over [0,3), response held under backpressure.
    clear_table();
    t_mode[2] = MODE_NAPOT; t_addr[2] = 32'h5FF; t_perm[2] = 3'b011;
    do_req(0, 3, 64'h8000, 4'd8, ACCESS_READ, lat);
    check_rsp("hold", lat, 4, 1'b0, 1'b0, 0, ERR_NO_HIT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_hit",   64'(rsp_hit),   64'd0);
      check("hold_err",   64'(rsp_err),   64'(ERR_NO_HIT));
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    ack_rsp("hold");

    // Flush in the same cycle as a hit on entry 1.
    clear_table();
    t_mode[1] = MODE_NAPOT; t_addr[1] = 32'h5FF; t_perm[1] = 3'b011;
    drive_req(0, 4, 64'h1010, 4'd4, ACCESS_READ);
    check("flush_idx0", 64'(entry_idx), 64'd0);
    @(negedge clk);
    check("flush_idx1", 64'(entry_idx), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_no_rsp",  64'(rsp_valid), 64'd0);
    check("flush_restart", 64'(entry_idx), 64'd0);
    @(negedge clk);
    check("flush_idx1_again", 64'(entry_idx), 64'd1);
    check("flush_no_rsp2",    64'(rsp_valid), 64'd0);
    @(negedge clk);
    check_rsp("flush", 5, 5, 1'b1, 1'b1, 1, ERR_NONE);
    ack_rsp("flush");

    // Asynchronous reset in the middle of a long walk.
    clear_table();
    drive_req(0, 64, 64'h8000, 4'd8, ACCESS_READ);
    @(negedge clk);
    check("rstw_idx", 64'(entry_idx), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstw_valid",     64'(rsp_valid), 64'd0);
    check("rstw_req_ready", 64'(req_ready), 64'd1);
    check("rstw_entry_idx", 64'(entry_idx), 64'd0);
    check("rstw_hit",       64'(rsp_hit),   64'd0);
    check("rstw_allow",     64'(rsp_allow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rstw_no_spurious", 64'(seen), 64'd0);

    do_req(5, 5, 64'h0, 4'd8, ACCESS_READ, lat);
    check_rsp("post_rst", lat, 1, 1'b0, 1'b0, 0, ERR_NO_HIT);
    ack_rsp("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
